fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It takes the datapath's PC and returns the 32-bit instruction word on Instr. It talks to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel. It holds the datapath's Stall input high until the instruction for the current PC is available, and can optionally prefetch PC+4.

---
 rtl/fetch_unit_if.sv | 16 +
 rtl/fetch_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request (valid/ready) and response (valid-only) channel
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: one-entry buffered instruction fetch with optional PC+4 prefetch and timeout error
// Ports: clk, reset (async active-low), PC in, Instr/Stall to the datapath,
// fetch_err sticky timeout flag, imem master side of fetch_unit_if.
module fetch_unit #(
  parameter bit PREFETCH = 1'b1,
  parameter int TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  PC,
  output logic [31:0]  Instr,
  output logic         Stall,
  output logic         fetch_err,
  fetch_unit_if.master imem
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
  state_t        state, state_nx;
  logic [29:0]   ibuf_tag, req_tag, req_tag_nx;
  logic [31:0]   ibuf_data;
  logic          ibuf_valid, hit, load;
  logic [CW-1:0] cnt, cnt_nx;
  assign hit                 = ibuf_valid && (ibuf_tag == PC[31:2]);
  assign Stall               = ~hit | (state == ERR);
  assign Instr               = ibuf_data;
  assign fetch_err           = state == ERR;
  assign imem.imem_req_valid = state == REQ;
  assign imem.imem_req_addr  = {req_tag, 2'b00};
  always_comb begin
    state_nx   = state;
    req_tag_nx = req_tag;
    cnt_nx     = cnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          req_tag_nx = PC[31:2];
          state_nx   = REQ;
        end else if (PREFETCH) begin
          req_tag_nx = PC[31:2] + 30'd1;
          state_nx   = REQ;
        end
      end
      REQ: begin
        if (imem.imem_req_ready) begin
          cnt_nx   = '0;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // the response always lands in the buffer; a stale tag just misses later
        if (imem.imem_rsp_valid) begin
          load     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx   = cnt + CW'(1);
          state_nx = (cnt == CW'(TIMEOUT - 1)) ? ERR : WAIT;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_tag    <= '0;
      cnt        <= '0;
      ibuf_tag   <= '0;
      ibuf_data  <= '0;
      ibuf_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      req_tag <= req_tag_nx;
      cnt     <= cnt_nx;
      if (load) begin
        ibuf_tag   <= req_tag;
        ibuf_data  <= imem.imem_rsp_data;
        ibuf_valid <= 1'b1;
      end
    end
  end
endmodule
